// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and multdiv start/wait with watchdog.
// Optional stall statistics counter is built when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl #(
  parameter int unsigned MD_MAX_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fd_IR,
  input  logic [31:0] dx_IR,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        xm_bubble,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        md_busy,
  output logic        md_error,
  output logic [31:0] stall_cycles
);

  typedef enum logic {RUN, MD_BUSY} state_e;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       md_error_q, md_error_d;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       dx_is_mul, dx_is_div, dx_is_md, load_use, timeout;
  logic       unused_bits;

  assign fd_op  = fd_IR[31:27];
  assign fd_rd  = fd_IR[26:22];
  assign fd_rs  = fd_IR[21:17];
  assign fd_rt  = fd_IR[16:12];
  assign dx_op  = dx_IR[31:27];
  assign dx_rd  = dx_IR[26:22];
  assign dx_alu = dx_IR[6:2];
  assign unused_bits = ^{fd_IR[11:0], dx_IR[21:7], dx_IR[1:0]};

  assign dx_is_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
  assign dx_is_div = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);
  assign dx_is_md  = dx_is_mul || dx_is_div;

  assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                    ((fd_rs == dx_rd) ||
                     ((fd_op == OP_RTYPE) && (fd_rt == dx_rd)) ||
                     ((fd_op == OP_SW) && (fd_rd == dx_rd)));

  // Counter holds (busy cycles - 1); this value means the next increment would reach the limit.
  assign timeout = (cnt_q == 8'(MD_MAX_CYCLES - 2));

  always_comb begin
    pc_en      = 1'b0;
    fd_en      = 1'b0;
    dx_en      = 1'b0;
    xm_en      = 1'b0;
    mw_en      = 1'b0;
    fd_flush   = 1'b0;
    dx_flush   = 1'b0;
    xm_bubble  = 1'b0;
    ctrl_MULT  = 1'b0;
    ctrl_DIV   = 1'b0;
    md_busy    = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_error_d = md_error_q;
    if (reset) begin
      unique case (state_q)
        RUN: begin
          cnt_d = '0;
          xm_en = 1'b1;
          mw_en = 1'b1;
          if (dx_is_md) begin
            xm_bubble = 1'b1;
            ctrl_MULT = dx_is_mul;
            ctrl_DIV  = dx_is_div;
            state_d   = MD_BUSY;
          end else if (load_use) begin
            dx_en    = 1'b1;
            dx_flush = 1'b1;
          end else begin
            pc_en = 1'b1;
            fd_en = 1'b1;
            dx_en = 1'b1;
            if (branch_taken) begin
              fd_flush = 1'b1;
              dx_flush = 1'b1;
            end
          end
        end
        MD_BUSY: begin
          md_busy = 1'b1;
          xm_en   = 1'b1;
          mw_en   = 1'b1;
          if (md_ready || timeout) begin
            pc_en   = 1'b1;
            fd_en   = 1'b1;
            dx_en   = 1'b1;
            cnt_d   = '0;
            state_d = RUN;
            if (!md_ready) md_error_d = 1'b1;
          end else begin
            xm_bubble = 1'b1;
            cnt_d     = cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      md_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_error_q <= md_error_d;
    end
  end

  assign md_error = md_error_q;

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, branch flush, multdiv wait, watchdog and reset abort.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fd_IR, dx_IR;
  logic        branch_taken, md_ready;
  logic        pc_en, fd_en, dx_en, xm_en, mw_en;
  logic        fd_flush, dx_flush, xm_bubble;
  logic        ctrl_MULT, ctrl_DIV, md_busy, md_error;
  logic [31:0] stall_cycles;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MD_MAX_CYCLES(40)) dut (
    .clk(clk), .reset(reset), .fd_IR(fd_IR), .dx_IR(dx_IR),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_bubble(xm_bubble),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .md_busy(md_busy),
    .md_error(md_error), .stall_cycles(stall_cycles)
  );

  // Packed view: {pc,fd,dx,xm,mw, fd_flush,dx_flush,xm_bubble, MULT,DIV, busy,error}
  localparam logic [11:0] V_RESET  = 12'h000;
  localparam logic [11:0] V_NORMAL = 12'hF80;
  localparam logic [11:0] V_LDUSE  = 12'h3A0;
  localparam logic [11:0] V_BRANCH = 12'hFE0;
  localparam logic [11:0] V_MUL    = 12'h198;
  localparam logic [11:0] V_DIV    = 12'h194;
  localparam logic [11:0] V_WAIT   = 12'h192;
  localparam logic [11:0] V_READY  = 12'hF82;
  localparam logic [11:0] ERR      = 12'h001;

  localparam logic [31:0] NOP = 32'h0;

`ifdef PIPE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  function automatic logic [11:0] ctrl_vec();
    return {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_bubble,
            ctrl_MULT, ctrl_DIV, md_busy, md_error};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_type(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic [11:0] exp);
    #1;
    check(tag, {20'd0, ctrl_vec()}, {20'd0, exp});
  endtask

  initial begin
    reset = 1'b0; fd_IR = NOP; dx_IR = NOP; branch_taken = 1'b0; md_ready = 1'b0;
    tick();
    chk_ctrl("reset_outputs", V_RESET);
    check("reset_stall", stall_cycles, 32'd0);
    reset = 1'b1;
    chk_ctrl("normal_nop", V_NORMAL);

    // Load-use via rs, then the flushed bubble lets the consumer advance.
    tick(); dx_IR = i_type(5'b01000, 5'd5, 5'd1, 17'd4); fd_IR = r_type(5'd6, 5'd5, 5'd2, 5'd0);
    chk_ctrl("lduse_rs", V_LDUSE);
    tick(); dx_IR = NOP;
    chk_ctrl("lduse_one_cycle", V_NORMAL);
    tick(); dx_IR = i_type(5'b01000, 5'd0, 5'd1, 17'd4); fd_IR = r_type(5'd6, 5'd0, 5'd2, 5'd0);
    chk_ctrl("lduse_r0_nostall", V_NORMAL);
    tick(); dx_IR = i_type(5'b01000, 5'd5, 5'd1, 17'd4); fd_IR = r_type(5'd6, 5'd2, 5'd5, 5'd0);
    chk_ctrl("lduse_rt", V_LDUSE);
    tick(); fd_IR = i_type(5'b00111, 5'd5, 5'd1, 17'd8);
    chk_ctrl("lduse_sw_rd", V_LDUSE);
    tick(); fd_IR = i_type(5'b01000, 5'd6, 5'd1, {5'd5, 12'd0});
    chk_ctrl("lduse_itype_rt_ignored", V_NORMAL);
    tick(); fd_IR = r_type(5'd6, 5'd5, 5'd2, 5'd0); branch_taken = 1'b1;
    chk_ctrl("lduse_over_branch", V_LDUSE);

    tick(); dx_IR = NOP; fd_IR = NOP; branch_taken = 1'b1;
    chk_ctrl("branch_flush", V_BRANCH);
    tick(); branch_taken = 1'b0;
    chk_ctrl("branch_one_cycle", V_NORMAL);

    // Fresh reset so stall statistics start from zero for the multiply.
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    check("stall_cleared", stall_cycles, 32'd0);

    tick(); dx_IR = r_type(5'd3, 5'd1, 5'd2, 5'b00110); branch_taken = 1'b1;
    chk_ctrl("mul_start_over_branch", V_MUL);
    for (int i = 1; i <= 31; i++) begin
      tick(); branch_taken = (i == 5);
      chk_ctrl($sformatf("mul_wait_%0d", i), V_WAIT);
    end
    tick(); md_ready = 1'b1; branch_taken = 1'b0;
    chk_ctrl("mul_ready", V_READY);
    tick(); md_ready = 1'b0;
    check("stall_after_mul", stall_cycles, STATS ? 32'd32 : 32'd0);
    chk_ctrl("mul_back_to_back", V_MUL);
    tick(); md_ready = 1'b1;
    chk_ctrl("mul_min_latency", V_READY);
    tick(); md_ready = 1'b0; dx_IR = NOP;
    chk_ctrl("run_after_mul", V_NORMAL);

    tick(); dx_IR = r_type(5'd4, 5'd1, 5'd2, 5'b00111);
    chk_ctrl("div_start", V_DIV);
    for (int i = 1; i <= 38; i++) begin
      tick();
      chk_ctrl($sformatf("div_wait_%0d", i), V_WAIT);
    end
    tick();
    chk_ctrl("div_timeout_cycle", V_READY);
    tick(); dx_IR = NOP;
    chk_ctrl("div_error_set", V_NORMAL | ERR);
    tick();
    chk_ctrl("div_error_sticky", V_NORMAL | ERR);

    tick(); dx_IR = r_type(5'd3, 5'd1, 5'd2, 5'b00110);
    chk_ctrl("abort_start", V_MUL | ERR);
    tick();
    chk_ctrl("abort_wait", V_WAIT | ERR);
    #2 reset = 1'b0;
    chk_ctrl("abort_reset_immediate", V_RESET);
    tick();
    chk_ctrl("abort_reset_held", V_RESET);
    reset = 1'b1; dx_IR = NOP;
    chk_ctrl("abort_restart_run", V_NORMAL);
    check("abort_stall_cleared", stall_cycles, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
